// File: rtl/mau_pkg.sv
// Shared types and helpers for the MAU dispatcher: instruction width, field
// extraction for the {op,a1,a2,b1,b2} packing, and lane-index sizing.
package mau_pkg;

    localparam int MAX_DW = 32;

    function automatic int instr_w(input int dw);
        return 5 * dw;
    endfunction

    // A single-lane build still needs a 1-bit pointer so ports stay legal.
    function automatic int lane_w(input int nlane);
        return (nlane > 1) ? $clog2(nlane) : 1;
    endfunction

    // idx 0 is op (MSBs), 4 is b2 (LSBs).
    function automatic logic [MAX_DW-1:0] instr_field(input logic [5*MAX_DW-1:0] instr,
                                                      input int dw, input int idx);
        logic [5*MAX_DW-1:0] shifted;
        logic [MAX_DW-1:0]   mask;
        shifted = instr >> ((4 - idx) * dw);
        mask    = {MAX_DW{1'b1}} >> (MAX_DW - dw);
        return shifted[MAX_DW-1:0] & mask;
    endfunction

    function automatic logic [MAX_DW-1:0] instr_op(input logic [5*MAX_DW-1:0] instr, input int dw);
        return instr_field(instr, dw, 0);
    endfunction

    function automatic logic [MAX_DW-1:0] instr_a1(input logic [5*MAX_DW-1:0] instr, input int dw);
        return instr_field(instr, dw, 1);
    endfunction

    function automatic logic [MAX_DW-1:0] instr_a2(input logic [5*MAX_DW-1:0] instr, input int dw);
        return instr_field(instr, dw, 2);
    endfunction

    function automatic logic [MAX_DW-1:0] instr_b1(input logic [5*MAX_DW-1:0] instr, input int dw);
        return instr_field(instr, dw, 3);
    endfunction

    function automatic logic [MAX_DW-1:0] instr_b2(input logic [5*MAX_DW-1:0] instr, input int dw);
        return instr_field(instr, dw, 4);
    endfunction

endpackage

// File: rtl/mau_sync_fifo.sv
// Instruction queue: DEPTH entries, extra pointer MSB distinguishes full from
// empty. Flush drops all queued entries by catching the read pointer up.
module mau_sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_wr_en = i_push & ~o_full & ~i_flush;
    assign w_rd_en = i_pop & ~o_empty & ~i_flush;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of the order the always blocks are evaluated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_flush) r_rd_ptr <= r_wr_ptr;
            else if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers define which
    // entries are meaningful, and leaving the array reset-free lets it map to RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/mau_dispatch.sv
// Multi-lane MAU dispatcher: queues RX instructions, issues them round-robin to
// NLANE lanes and retires lane results strictly in issue order toward TX.
module mau_dispatch
    import mau_pkg::*;
#(
    parameter int DW           = 8,
    parameter int DEPTH        = 4,
    parameter int NLANE        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int RES_W        = 2*DW+2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [5*DW-1:0]                   in_instr,
    input  logic                              flush,
    output logic [NLANE-1:0]                  lane_cmd_valid,
    input  logic [NLANE-1:0]                  lane_cmd_ready,
    output logic [5*DW-1:0]                   lane_cmd_instr,
    input  logic [NLANE-1:0]                  lane_res_valid,
    output logic [NLANE-1:0]                  lane_res_ready,
    input  logic [NLANE*RES_W-1:0]            lane_res_data,
    input  logic [NLANE-1:0]                  lane_res_carry,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [RES_W-1:0]                  out_data,
    output logic                              out_carry,
    output logic [$clog2(DEPTH):0]            q_count,
    output logic [$clog2(MAX_INFLIGHT):0]     inflight,
    output logic                              busy
);

    localparam int INSTR_W = instr_w(DW);
    localparam int LW      = lane_w(NLANE);
    localparam int IW      = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(NLANE - 1);

    logic [LW-1:0]      r_issue_ptr;
    logic [LW-1:0]      r_retire_ptr;
    logic [IW-1:0]      r_inflight;
    logic               r_out_valid;
    logic [RES_W-1:0]   r_out_data;
    logic               r_out_carry;

    logic               w_q_full;
    logic               w_q_empty;
    logic               w_push;
    logic               w_issue_ok;
    logic               w_dispatch;
    logic               w_retire_ok;
    logic               w_retire;
    logic [INSTR_W-1:0] w_head;

    function automatic logic [LW-1:0] next_lane(input logic [LW-1:0] ptr);
        return (ptr == LAST_LANE) ? '0 : ptr + 1'b1;
    endfunction

    mau_sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_dispatch),
        .i_flush (flush),
        .i_data  (in_instr),
        .o_data  (w_head),
        .o_count (q_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    // in_ready looks only at the current occupancy; no credit for a same-cycle pop.
    assign in_ready    = rst_n & ~w_q_full & ~flush;
    assign w_push      = in_valid & in_ready;
    assign w_issue_ok  = rst_n & ~w_q_empty & (r_inflight < IW'(MAX_INFLIGHT)) & ~flush;
    assign w_dispatch  = w_issue_ok & lane_cmd_ready[r_issue_ptr];
    assign w_retire_ok = rst_n & (r_inflight != '0) & (~r_out_valid | out_ready);
    assign w_retire    = w_retire_ok & lane_res_valid[r_retire_ptr];

    // NOTE: defaults first so every bit of these outputs is assigned on every
    // path; otherwise the one-hot index write would infer latches.
    always_comb begin
        lane_cmd_valid = '0;
        lane_res_ready = '0;
        lane_cmd_valid[r_issue_ptr]  = w_issue_ok;
        lane_res_ready[r_retire_ptr] = w_retire_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_issue_ptr  <= '0;
            r_retire_ptr <= '0;
            r_inflight   <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_carry  <= 1'b0;
        end else begin
            if (w_dispatch) r_issue_ptr  <= next_lane(r_issue_ptr);
            if (w_retire)   r_retire_ptr <= next_lane(r_retire_ptr);

            case ({w_dispatch, w_retire})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase

            // A capture in the drain cycle replaces the register, one result per cycle.
            if (w_retire) begin
                r_out_valid <= 1'b1;
                r_out_data  <= lane_res_data[r_retire_ptr*RES_W +: RES_W];
                r_out_carry <= lane_res_carry[r_retire_ptr];
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
                r_out_carry <= 1'b0;
            end
        end
    end

    assign lane_cmd_instr = w_head;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_carry      = r_out_carry;
    assign inflight       = r_inflight;
    assign busy           = (q_count != '0) | (r_inflight != '0) | r_out_valid;

endmodule
